// File: rtl/agc_ctrl_pkg.sv
// Shared constants, FSM state type and saturating helpers for the AGC gain scheduler.
package agc_ctrl_pkg;

  localparam int unsigned DW          = 8;
  localparam int unsigned GW          = 6;
  localparam int unsigned GMAX        = (1 << GW) - 1;
  localparam int unsigned WIN_LOG2    = 4;
  localparam int unsigned TARGET      = 96;
  localparam int unsigned HYST        = 16;
  localparam int unsigned ATTACK_STEP = 4;
  localparam int unsigned DECAY_STEP  = 1;
  localparam int unsigned HOLD_WINS   = 3;
  localparam int unsigned GAIN_INIT   = 32;

  localparam int unsigned MAG_MAX = (1 << (DW - 1)) - 1;
  localparam int unsigned HI_THR  = TARGET + HYST;
  localparam int unsigned LO_THR  = TARGET - HYST;
  localparam int unsigned HW      = (HOLD_WINS > 1) ? $clog2(HOLD_WINS) : 1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StMeasure = 2'd1,
    StAdjust  = 2'd2
  } agc_state_e;

  // Most negative sample folds onto the largest positive magnitude.
  function automatic logic [DW-1:0] sat_mag(input logic [DW-1:0] s);
    logic [DW-1:0] m;
    if (!s[DW-1]) begin
      m = s;
    end else if (s == {1'b1, {(DW - 1){1'b0}}}) begin
      m = DW'(MAG_MAX);
    end else begin
      m = -s;
    end
    return m;
  endfunction

  function automatic logic [GW-1:0] sat_sub(input logic [GW-1:0] a, input int unsigned step);
    logic [GW-1:0] r;
    r = '0;
    if (32'(a) >= step) begin
      r = GW'(32'(a) - step);
    end
    return r;
  endfunction

  function automatic logic [GW-1:0] sat_add(input logic [GW-1:0] a, input int unsigned step);
    logic [GW-1:0] r;
    r = GW'(GMAX);
    if (32'(a) + step <= GMAX) begin
      r = GW'(32'(a) + step);
    end
    return r;
  endfunction

endpackage

// File: rtl/agc_peak_window.sv
// Per-window peak tracker: sample magnitude, running peak, sample count and
// once-per-window full-scale (clip) detection.
module agc_peak_window
  import agc_ctrl_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 measure_i,
  input  logic                 restart_i,
  input  logic                 valid_i,
  input  logic signed [DW-1:0] sample_i,
  output logic                 last_o,
  output logic                 clip_hit_o,
  output logic        [DW-1:0] win_peak_o
);

  localparam logic [WIN_LOG2-1:0] LastCnt = '1;

  logic [DW-1:0]       mag;
  logic [DW-1:0]       peak_q;
  logic [WIN_LOG2-1:0] win_cnt_q;
  logic                clip_done_q;

  always_comb begin
    mag        = sat_mag(sample_i);
    win_peak_o = (mag > peak_q) ? mag : peak_q;
    last_o     = measure_i && valid_i && (win_cnt_q == LastCnt);
    clip_hit_o = measure_i && valid_i && (32'(mag) == MAG_MAX) && !clip_done_q;
  end

  // Outside measure/adjust the partial window is discarded. During adjust a
  // valid sample opens the next window so nothing is dropped.
  always_ff @(posedge clk_i) begin
    if (reset_i || !(measure_i || restart_i)) begin
      peak_q      <= '0;
      win_cnt_q   <= '0;
      clip_done_q <= 1'b0;
    end else if (restart_i) begin
      clip_done_q <= 1'b0;
      peak_q      <= valid_i ? mag : '0;
      win_cnt_q   <= valid_i ? WIN_LOG2'(1) : '0;
    end else if (valid_i) begin
      peak_q      <= win_peak_o;
      win_cnt_q   <= win_cnt_q + 1'b1;
      clip_done_q <= clip_done_q | clip_hit_o;
    end
  end

endmodule

// File: rtl/agc_gain_ctrl.sv
// Closed-loop AGC gain scheduler: steps the gain code down on loud windows or
// full-scale samples and back up after a run of quiet windows.
module agc_gain_ctrl
  import agc_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_x,
  input  logic                 enable,
  input  logic                 sample_valid,
  input  logic signed [DW-1:0] sample_in,
  output logic        [GW-1:0] gain,
  output logic                 gain_update,
  output logic        [DW-1:0] peak_out,
  output logic                 clip,
  output logic        [1:0]    state_out
);

  agc_state_e    state_q;
  logic [GW-1:0] gain_q;
  logic [HW-1:0] hold_cnt_q;
  logic [DW-1:0] peak_out_q;
  logic          gain_update_q;
  logic          clip_q;

  logic          run_measure;
  logic          run_adjust;
  logic          last;
  logic          clip_hit;
  logic [DW-1:0] win_peak;
  logic [GW-1:0] gain_atk;
  logic [GW-1:0] gain_dec;

  always_comb begin
    run_measure = enable && (state_q == StMeasure);
    run_adjust  = enable && (state_q == StAdjust);
    gain_atk    = sat_sub(gain_q, ATTACK_STEP);
    gain_dec    = sat_add(gain_q, DECAY_STEP);
  end

  agc_peak_window u_peak_window (
    .clk_i      (clk),
    .reset_i    (reset_x),
    .measure_i  (run_measure),
    .restart_i  (run_adjust),
    .valid_i    (sample_valid),
    .sample_i   (sample_in),
    .last_o     (last),
    .clip_hit_o (clip_hit),
    .win_peak_o (win_peak)
  );

  always_ff @(posedge clk) begin
    if (reset_x) begin
      state_q       <= StIdle;
      gain_q        <= GW'(GAIN_INIT);
      hold_cnt_q    <= '0;
      peak_out_q    <= '0;
      gain_update_q <= 1'b0;
      clip_q        <= 1'b0;
    end else begin
      gain_update_q <= 1'b0;
      clip_q        <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            state_q <= StMeasure;
          end
        end
        StMeasure: begin
          if (!enable) begin
            state_q    <= StIdle;
            hold_cnt_q <= '0;
          end else begin
            if (clip_hit) begin
              gain_q        <= gain_atk;
              gain_update_q <= (gain_atk != gain_q);
              clip_q        <= 1'b1;
            end
            if (last) begin
              peak_out_q <= win_peak;
              state_q    <= StAdjust;
            end
          end
        end
        StAdjust: begin
          if (!enable) begin
            state_q    <= StIdle;
            hold_cnt_q <= '0;
          end else begin
            state_q <= StMeasure;
            if (32'(peak_out_q) > HI_THR) begin
              gain_q        <= gain_atk;
              gain_update_q <= (gain_atk != gain_q);
              hold_cnt_q    <= '0;
            end else if (32'(peak_out_q) < LO_THR) begin
              // Decay only after HOLD_WINS consecutive quiet windows.
              if (32'(hold_cnt_q) == HOLD_WINS - 1) begin
                gain_q        <= gain_dec;
                gain_update_q <= (gain_dec != gain_q);
                hold_cnt_q    <= '0;
              end else begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
              end
            end else begin
              hold_cnt_q <= '0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    gain        = gain_q;
    gain_update = gain_update_q;
    peak_out    = peak_out_q;
    clip        = clip_q;
    state_out   = state_q;
  end

endmodule

// File: tb/tb_agc_gain_ctrl.sv
// Table-driven bench for agc_gain_ctrl: one record per clock of inputs and
// hand-computed outputs expected just after that edge.
module tb_agc_gain_ctrl;

  logic              clk;
  logic              reset_x;
  logic              enable;
  logic              sample_valid;
  logic signed [7:0] sample_in;
  logic [5:0]        gain;
  logic              gain_update;
  logic [7:0]        peak_out;
  logic              clip;
  logic [1:0]        state_out;

  typedef struct {
    logic       rst;
    logic       en;
    logic       v;
    logic [7:0] s;
    logic [5:0] g;
    logic       upd;
    logic       clp;
    logic [1:0] st;
    logic [7:0] pk;
  } vec_t;

  vec_t vecs[$];
  int   n_checks;
  int   n_fail;

  agc_gain_ctrl dut (
    .clk          (clk),
    .reset_x      (reset_x),
    .enable       (enable),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .gain         (gain),
    .gain_update  (gain_update),
    .peak_out     (peak_out),
    .clip         (clip),
    .state_out    (state_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push(input int rst, input int en, input int v, input int s, input int g,
                      input int upd, input int clp, input int st, input int pk);
    vec_t r;
    r.rst = 1'(rst);
    r.en  = 1'(en);
    r.v   = 1'(v);
    r.s   = 8'(s);
    r.g   = 6'(g);
    r.upd = 1'(upd);
    r.clp = 1'(clp);
    r.st  = 2'(st);
    r.pk  = 8'(pk);
    vecs.push_back(r);
  endtask

  // Reset then enable: gain back to 32, state MEASURE one edge later.
  task automatic restart();
    push(1, 0, 0, 0, 32, 0, 0, 0, 0);
    push(0, 1, 0, 0, 32, 0, 0, 1, 0);
  endtask

  // Full window of one sample value, then the adjust cycle with no sample.
  task automatic win(input int s, input int g0, input int g1, input int pk0, input int pk1);
    for (int i = 0; i < 15; i++) push(0, 1, 1, s, g0, 0, 0, 1, pk0);
    push(0, 1, 1, s, g0, 0, 0, 2, pk1);
    push(0, 1, 0, 0, g1, (g1 != g0) ? 1 : 0, 0, 1, pk1);
  endtask

  task automatic chk(input string name, input int idx, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL vec %0d %s: got %0d expected %0d", idx, name, got, exp);
    end
  endtask

  task automatic build();
    // Reset mid-stream after a clip attack restores everything.
    push(1, 0, 0, 0, 32, 0, 0, 0, 0);
    push(0, 1, 0, 0, 32, 0, 0, 1, 0);
    push(0, 1, 1, -128, 28, 1, 1, 1, 0);
    push(0, 1, 1, 10, 28, 0, 0, 1, 0);
    push(1, 1, 1, 127, 32, 0, 0, 0, 0);
    push(1, 1, 1, 127, 32, 0, 0, 0, 0);
    push(0, 1, 0, 0, 32, 0, 0, 1, 0);
    // Loud window attacks.
    win(120, 32, 28, 0, 120);
    // Three quiet windows give one decay.
    restart();
    win(-40, 32, 32, 0, 40);
    win(-40, 32, 32, 40, 40);
    win(-40, 32, 33, 40, 40);
    // In-band window resets the hold-off.
    restart();
    win(-40, 32, 32, 0, 40);
    win(-40, 32, 32, 40, 40);
    win(96, 32, 32, 40, 96);
    win(-40, 32, 32, 96, 40);
    win(-40, 32, 32, 40, 40);
    // Band edges are inclusive.
    restart();
    win(112, 32, 32, 0, 112);
    win(113, 32, 28, 112, 113);
    win(80, 28, 28, 113, 80);
    win(79, 28, 28, 80, 79);
    win(79, 28, 28, 79, 79);
    win(79, 28, 29, 79, 79);
    // Clip at position 5, second full-scale ignored, window attack follows.
    restart();
    for (int i = 0; i < 16; i++) begin
      push(0, 1, 1, (i == 5 || i == 9) ? -128 : 10, (i >= 5) ? 28 : 32, (i == 5) ? 1 : 0,
           (i == 5) ? 1 : 0, (i == 15) ? 2 : 1, (i == 15) ? 127 : 0);
    end
    push(0, 1, 0, 0, 24, 1, 0, 1, 127);
    // Clip on the last sample: clip attack then adjust attack.
    restart();
    for (int i = 0; i < 15; i++) push(0, 1, 1, 10, 32, 0, 0, 1, 0);
    push(0, 1, 1, 127, 28, 1, 1, 2, 127);
    push(0, 1, 0, 0, 24, 1, 0, 1, 127);
    // Sample during adjust opens the next window; a gap does not count.
    restart();
    for (int i = 0; i < 15; i++) push(0, 1, 1, 10, 32, 0, 0, 1, 0);
    push(0, 1, 1, 10, 32, 0, 0, 2, 10);
    push(0, 1, 1, 120, 32, 0, 0, 1, 10);
    for (int i = 0; i < 7; i++) push(0, 1, 1, 10, 32, 0, 0, 1, 10);
    push(0, 1, 0, 0, 32, 0, 0, 1, 10);
    for (int i = 0; i < 7; i++) push(0, 1, 1, 10, 32, 0, 0, 1, 10);
    push(0, 1, 1, 10, 32, 0, 0, 2, 120);
    push(0, 1, 0, 0, 28, 1, 0, 1, 120);
    // Walk gain to 2, then saturate at 0.
    restart();
    win(-40, 32, 32, 0, 40);
    win(-40, 32, 32, 40, 40);
    win(-40, 32, 33, 40, 40);
    win(-40, 33, 33, 40, 40);
    win(-40, 33, 33, 40, 40);
    win(-40, 33, 34, 40, 40);
    win(120, 34, 30, 40, 120);
    for (int k = 1; k < 8; k++) win(120, 34 - 4 * k, 30 - 4 * k, 120, 120);
    win(120, 2, 0, 120, 120);
    win(120, 0, 0, 120, 120);
    // Drop enable mid-window: idle, partial window discarded.
    for (int i = 0; i < 7; i++) push(0, 1, 1, 120, 0, 0, 0, 1, 120);
    for (int i = 0; i < 3; i++) push(0, 0, 1, 127, 0, 0, 0, 0, 120);
    push(0, 1, 0, 0, 0, 0, 0, 1, 120);
    win(-40, 0, 0, 120, 40);
    // Drop enable during adjust: no update.
    restart();
    for (int i = 0; i < 15; i++) push(0, 1, 1, 120, 32, 0, 0, 1, 0);
    push(0, 1, 1, 120, 32, 0, 0, 2, 120);
    push(0, 0, 0, 0, 32, 0, 0, 0, 120);
    push(0, 1, 0, 0, 32, 0, 0, 1, 120);
    win(120, 32, 28, 120, 120);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset_x      = 1'b1;
    enable       = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    build();
    for (int i = 0; i < vecs.size(); i++) begin
      reset_x      = vecs[i].rst;
      enable       = vecs[i].en;
      sample_valid = vecs[i].v;
      sample_in    = vecs[i].s;
      @(posedge clk);
      #1;
      chk("gain", i, int'(gain), int'(vecs[i].g));
      chk("gain_update", i, int'(gain_update), int'(vecs[i].upd));
      chk("clip", i, int'(clip), int'(vecs[i].clp));
      chk("state_out", i, int'(state_out), int'(vecs[i].st));
      chk("peak_out", i, int'(peak_out), int'(vecs[i].pk));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
